key_move_decoder: RTL and testbench

- Sits directly downstream of the 4x4 keypad scanner.
- Consumes the scanner's held-key level (key_valid) and 4-bit key code.
- Produces debounced, single-cycle game commands: a move with a direction, or restart.
- Held direction keys auto-repeat; results feed the maze position logic.

---
 rtl/key_move_decoder_pkg.sv | 41 ++++
 rtl/key_move_decoder_if.sv | 22 ++
 rtl/key_move_decoder_hold_timer.sv | 39 +++
 rtl/key_move_decoder.sv | 188 ++++++++++++++++++
 tb/tb_key_move_decoder.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_move_decoder_pkg.sv
// Shared definitions for the keypad move decoder: key codes, move
// directions and FSM state encoding.
package key_pkg;

  localparam logic [3:0] KEY_UP      = 4'd1;
  localparam logic [3:0] KEY_DOWN    = 4'd9;
  localparam logic [3:0] KEY_LEFT    = 4'd4;
  localparam logic [3:0] KEY_RIGHT   = 4'd6;
  localparam logic [3:0] KEY_RESTART = 4'd15;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // True for the four keys that produce a move command.
  function automatic logic is_dir_key(input logic [3:0] code);
    return (code == KEY_UP) || (code == KEY_DOWN) ||
           (code == KEY_LEFT) || (code == KEY_RIGHT);
  endfunction

  // Direction encoding for a move key; callers only use it when is_dir_key().
  function automatic dir_t dir_of_key(input logic [3:0] code);
    case (code)
      KEY_DOWN:  return DIR_DOWN;
      KEY_LEFT:  return DIR_LEFT;
      KEY_RIGHT: return DIR_RIGHT;
      default:   return DIR_UP;
    endcase
  endfunction

endpackage

// File: rtl/key_move_decoder_if.sv
// Bundle between the keypad scanner side and the move decoder.
interface key_move_decoder_if;
  logic       key_valid;
  logic [3:0] key_value;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       restart_pulse;
  logic       key_held;
  logic [3:0] last_key;

  // Scanner / consumer side.
  modport master (
    output key_valid, key_value,
    input  move_valid, move_dir, restart_pulse, key_held, last_key
  );

  // Decoder side.
  modport slave (
    input  key_valid, key_value,
    output move_valid, move_dir, restart_pulse, key_held, last_key
  );
endinterface

// File: rtl/key_move_decoder_hold_timer.sv
// Loadable saturating up/down counter used for debounce and auto-repeat
// timing. Load has priority over counting; the count never wraps.
module key_hold_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             at_one_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: load, else saturating increment or decrement.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o  = count_q;
  assign at_one_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/key_move_decoder.sv
// Debounces the scanner's held-key level and turns accepted keys into
// single-cycle move / restart commands, with auto-repeat on held moves.
module key_move_decoder
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned REPEAT_DELAY    = 25000,
  parameter int unsigned REPEAT_PERIOD   = 10000,
  parameter int unsigned CNT_W           = 16
) (
  input logic              clk,
  input logic              reset,
  key_move_decoder_if.slave kif
);

  if (DEBOUNCE_CYCLES == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_zero_param
    $error("key_move_decoder: timing parameters must be non-zero");
  end
  if ((DEBOUNCE_CYCLES >> CNT_W) != 0 || (REPEAT_DELAY >> CNT_W) != 0 ||
      (REPEAT_PERIOD >> CNT_W) != 0) begin : g_width_param
    $error("key_move_decoder: CNT_W too narrow for timing parameters");
  end

  state_t     state_q;
  logic [3:0] code_q;
  logic       accept_q;
  logic       move_valid_q;
  dir_t       move_dir_q;
  logic       restart_q;
  logic       key_held_q;
  logic [3:0] last_key_q;

  logic             tmr_load_d;
  logic [CNT_W-1:0] tmr_val_d;
  logic             tmr_inc_d;
  logic             tmr_dec_d;
  logic [CNT_W-1:0] tmr_cnt;
  logic             tmr_at_one;

  logic same_key, new_key, at_db;

  assign same_key = kif.key_valid && (kif.key_value == code_q);
  assign new_key  = kif.key_valid && (kif.key_value != code_q);
  assign at_db    = (tmr_cnt == CNT_W'(DEBOUNCE_CYCLES));

  key_hold_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tmr_load_d),
    .load_val_i(tmr_val_d),
    .inc_i     (tmr_inc_d),
    .dec_i     (tmr_dec_d),
    .count_o   (tmr_cnt),
    .at_one_o  (tmr_at_one)
  );

  // Timer control derived from the current state and keypad input.
  always_comb begin
    tmr_load_d = 1'b0;
    tmr_val_d  = '0;
    tmr_inc_d  = 1'b0;
    tmr_dec_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (kif.key_valid) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = CNT_W'(1);
        end
      end
      DEBOUNCE: begin
        if (new_key) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = CNT_W'(1);
        end else if (same_key && !at_db) begin
          tmr_inc_d = 1'b1;
        end
      end
      HELD: begin
        if (accept_q) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = CNT_W'(REPEAT_DELAY);
        end else if (!kif.key_valid || new_key) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = CNT_W'(1);
        end else if (tmr_at_one) begin
          // Non-move keys park at 1: they never repeat.
          if (is_dir_key(code_q)) begin
            tmr_load_d = 1'b1;
            tmr_val_d  = CNT_W'(REPEAT_PERIOD);
          end
        end else begin
          tmr_dec_d = 1'b1;
        end
      end
      RELEASE: begin
        if (!kif.key_valid) begin
          tmr_inc_d = !at_db;
        end else if (same_key) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = CNT_W'(REPEAT_DELAY);
        end else begin
          tmr_load_d = 1'b1;
          tmr_val_d  = CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Decoder FSM with registered command outputs. Acceptance happens in the
  // first HELD cycle (accept_q), one cycle after debounce completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      code_q       <= 4'd0;
      accept_q     <= 1'b0;
      move_valid_q <= 1'b0;
      move_dir_q   <= DIR_UP;
      restart_q    <= 1'b0;
      key_held_q   <= 1'b0;
      last_key_q   <= 4'd0;
    end else begin
      move_valid_q <= 1'b0;
      restart_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (kif.key_valid) begin
            code_q  <= kif.key_value;
            state_q <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!kif.key_valid) begin
            state_q <= IDLE;
          end else if (new_key) begin
            code_q <= kif.key_value;
          end else if (at_db) begin
            state_q  <= HELD;
            accept_q <= 1'b1;
          end
        end
        HELD: begin
          if (accept_q) begin
            accept_q   <= 1'b0;
            last_key_q <= code_q;
            key_held_q <= 1'b1;
            if (is_dir_key(code_q)) begin
              move_valid_q <= 1'b1;
              move_dir_q   <= dir_of_key(code_q);
            end else if (code_q == KEY_RESTART) begin
              restart_q <= 1'b1;
            end
          end else if (new_key) begin
            code_q     <= kif.key_value;
            key_held_q <= 1'b0;
            state_q    <= DEBOUNCE;
          end else if (!kif.key_valid) begin
            state_q <= RELEASE;
          end else if (tmr_at_one && is_dir_key(code_q)) begin
            move_valid_q <= 1'b1;
          end
        end
        RELEASE: begin
          if (!kif.key_valid) begin
            if (at_db) begin
              key_held_q <= 1'b0;
              state_q    <= IDLE;
            end
          end else if (same_key) begin
            state_q <= HELD;
          end else begin
            code_q     <= kif.key_value;
            key_held_q <= 1'b0;
            state_q    <= DEBOUNCE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign kif.move_valid    = move_valid_q;
  assign kif.move_dir      = move_dir_q;
  assign kif.restart_pulse = restart_q;
  assign kif.key_held      = key_held_q;
  assign kif.last_key      = last_key_q;

endmodule

// File: tb/tb_key_move_decoder.sv
// Directed bench for key_move_decoder with short timing parameters.
module tb_key_move_decoder;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  key_move_decoder_if kif();

  key_move_decoder #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8),
    .CNT_W          (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kif  (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; outputs are then stable and inputs may change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    kif.key_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    kif.key_valid = 1'b0;
    kif.key_value = 4'd0;
    step();
    step();
    checks += 5;
    if (kif.move_valid !== 1'b0) begin errors++; $display("FAIL reset_move_valid got %b want 0", kif.move_valid); end
    if (kif.move_dir !== 2'd0) begin errors++; $display("FAIL reset_move_dir got %0d want 0", kif.move_dir); end
    if (kif.restart_pulse !== 1'b0) begin errors++; $display("FAIL reset_restart got %b want 0", kif.restart_pulse); end
    if (kif.key_held !== 1'b0) begin errors++; $display("FAIL reset_key_held got %b want 0", kif.key_held); end
    if (kif.last_key !== 4'd0) begin errors++; $display("FAIL reset_last_key got %0d want 0", kif.last_key); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_press();
    int pulses = 0;
    int first = -1;
    int drop = -1;
    kif.key_value = 4'd6;
    kif.key_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (kif.move_valid === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        checks++;
        if (kif.move_dir !== 2'd3) begin errors++; $display("FAIL press_dir got %0d want 3", kif.move_dir); end
      end
    end
    checks += 4;
    if (pulses != 1) begin errors++; $display("FAIL press_pulse_count got %0d want 1", pulses); end
    if (first != 5) begin errors++; $display("FAIL press_latency got %0d want 5", first); end
    if (kif.key_held !== 1'b1) begin errors++; $display("FAIL press_key_held got %b want 1", kif.key_held); end
    if (kif.last_key !== 4'd6) begin errors++; $display("FAIL press_last_key got %0d want 6", kif.last_key); end
    kif.key_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      step();
      if (drop < 0 && kif.key_held === 1'b0) drop = j;
    end
    checks++;
    if (drop != 4) begin errors++; $display("FAIL release_delay got %0d want 4", drop); end
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    int bounce_pulses = 0;
    int pulses = 0;
    int first = -1;
    pat = 6'b011011;  // applied LSB first: 1,1,0,1,1,0
    kif.key_value = 4'd1;
    for (int i = 0; i < 6; i++) begin
      kif.key_valid = pat[i];
      step();
      if (kif.move_valid === 1'b1 || kif.restart_pulse === 1'b1) bounce_pulses++;
    end
    checks++;
    if (bounce_pulses != 0) begin errors++; $display("FAIL bounce_pulses got %0d want 0", bounce_pulses); end
    kif.key_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (kif.move_valid === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        checks++;
        if (kif.move_dir !== 2'd0) begin errors++; $display("FAIL bounce_dir got %0d want 0", kif.move_dir); end
      end
    end
    checks += 2;
    if (pulses != 1) begin errors++; $display("FAIL bounce_pulse_count got %0d want 1", pulses); end
    if (first != 5) begin errors++; $display("FAIL bounce_latency got %0d want 5", first); end
    idle_cycles(8);
  endtask

  task automatic test_repeat();
    int idx[8];
    int n = 0;
    int exp_idx[6] = '{5, 25, 33, 41, 49, 57};
    kif.key_value = 4'd9;
    kif.key_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (kif.move_valid === 1'b1) begin
        if (n < 8) idx[n] = i;
        n++;
        checks++;
        if (kif.move_dir !== 2'd1) begin errors++; $display("FAIL repeat_dir at %0d got %0d want 1", i, kif.move_dir); end
      end
    end
    checks++;
    if (n != 6) begin errors++; $display("FAIL repeat_count got %0d want 6", n); end
    for (int k = 0; k < 6; k++) begin
      if (k < n) begin
        checks++;
        if (idx[k] != exp_idx[k]) begin errors++; $display("FAIL repeat_time[%0d] got %0d want %0d", k, idx[k], exp_idx[k]); end
      end
    end
    idle_cycles(8);
  endtask

  task automatic test_restart();
    int rst_pulses = 0;
    int mv_pulses = 0;
    int late_pulses = 0;
    kif.key_value = 4'd15;
    kif.key_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (kif.restart_pulse === 1'b1) rst_pulses++;
      if (kif.move_valid === 1'b1) mv_pulses++;
    end
    checks += 3;
    if (rst_pulses != 1) begin errors++; $display("FAIL restart_count got %0d want 1", rst_pulses); end
    if (mv_pulses != 0) begin errors++; $display("FAIL restart_moves got %0d want 0", mv_pulses); end
    if (kif.last_key !== 4'd15) begin errors++; $display("FAIL restart_last_key got %0d want 15", kif.last_key); end
    kif.key_value = 4'd2;
    for (int i = 0; i < 10; i++) begin
      step();
      if (kif.restart_pulse === 1'b1 || kif.move_valid === 1'b1) late_pulses++;
    end
    checks += 2;
    if (late_pulses != 0) begin errors++; $display("FAIL unmapped_pulses got %0d want 0", late_pulses); end
    if (kif.last_key !== 4'd2) begin errors++; $display("FAIL unmapped_last_key got %0d want 2", kif.last_key); end
    idle_cycles(8);
  endtask

  task automatic test_release_glitch();
    int pulses = 0;
    int glitch_pulses = 0;
    int held_drops = 0;
    int first = -1;
    kif.key_value = 4'd4;
    kif.key_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (kif.move_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL glitch_first_count got %0d want 1", pulses); end
    kif.key_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (kif.key_held !== 1'b1) held_drops++;
      if (kif.move_valid === 1'b1) glitch_pulses++;
    end
    kif.key_valid = 1'b1;
    for (int j = 0; j < 25; j++) begin
      step();
      if (kif.key_held !== 1'b1) held_drops++;
      if (kif.move_valid === 1'b1) begin
        if (first < 0) begin
          first = j;
          checks++;
          if (kif.move_dir !== 2'd2) begin errors++; $display("FAIL glitch_dir got %0d want 2", kif.move_dir); end
        end
      end
    end
    checks += 3;
    if (glitch_pulses != 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", glitch_pulses); end
    if (held_drops != 0) begin errors++; $display("FAIL glitch_key_held drops got %0d want 0", held_drops); end
    if (first != 20) begin errors++; $display("FAIL glitch_repeat got %0d want 20", first); end
    idle_cycles(8);
  endtask

  task automatic test_key_change();
    int first = -1;
    int pulses = 0;
    kif.key_value = 4'd1;
    kif.key_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (kif.move_valid === 1'b1 && first < 0) first = i;
    end
    checks += 2;
    if (first != 5) begin errors++; $display("FAIL change_first got %0d want 5", first); end
    if (kif.move_dir !== 2'd0) begin errors++; $display("FAIL change_first_dir got %0d want 0", kif.move_dir); end
    first = -1;
    kif.key_value = 4'd6;
    for (int j = 0; j < 10; j++) begin
      step();
      if (kif.move_valid === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = j;
          checks++;
          if (kif.move_dir !== 2'd3) begin errors++; $display("FAIL change_dir got %0d want 3", kif.move_dir); end
        end
      end
    end
    checks += 2;
    if (first != 5) begin errors++; $display("FAIL change_latency got %0d want 5", first); end
    if (pulses != 1) begin errors++; $display("FAIL change_count got %0d want 1", pulses); end
    idle_cycles(8);
  endtask

  task automatic test_reset_mid_debounce();
    int pulses = 0;
    kif.key_value = 4'd6;
    kif.key_valid = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    checks += 5;
    if (kif.move_valid !== 1'b0) begin errors++; $display("FAIL midrst_move_valid got %b want 0", kif.move_valid); end
    if (kif.move_dir !== 2'd0) begin errors++; $display("FAIL midrst_move_dir got %0d want 0", kif.move_dir); end
    if (kif.restart_pulse !== 1'b0) begin errors++; $display("FAIL midrst_restart got %b want 0", kif.restart_pulse); end
    if (kif.key_held !== 1'b0) begin errors++; $display("FAIL midrst_key_held got %b want 0", kif.key_held); end
    if (kif.last_key !== 4'd0) begin errors++; $display("FAIL midrst_last_key got %0d want 0", kif.last_key); end
    reset = 1'b0;
    kif.key_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (kif.move_valid === 1'b1 || kif.restart_pulse === 1'b1 || kif.key_held === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL midrst_activity got %0d want 0", pulses); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    kif.key_valid = 1'b0;
    kif.key_value = 4'd0;
    test_reset();
    test_single_press();
    test_bounce();
    test_repeat();
    test_restart();
    test_release_glitch();
    test_key_change();
    test_reset_mid_debounce();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
